// File: rtl/tape_writer.sv
// Writes `a` ones, a zero separator, then `b` ones onto the unary tape, one cell per clock.
// Define TAPE_WRITER_REWIND_EN to walk the head back to cell 1 before signalling done.
module tape_writer #(
  parameter int TAPE_LEN = 10,
  parameter int CNT_W    = 4,
  parameter int HEAD_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    a,
  input  logic [CNT_W-1:0]    b,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:TAPE_LEN]   tape,
  output logic [HEAD_W-1:0]   head
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_WR_A   = 3'd2,
    S_SEP    = 3'd3,
    S_WR_B   = 3'd4,
`ifdef TAPE_WRITER_REWIND_EN
    S_REWIND = 3'd5,
`endif
    S_FIN    = 3'd6
  } state_t;

`ifdef TAPE_WRITER_REWIND_EN
  localparam state_t AFTER_B = S_REWIND;
`else
  localparam state_t AFTER_B = S_FIN;
`endif

  state_t state, state_next;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic [CNT_W+1:0] need;
  logic             fits;

  // Two extra bits so a+b+1 cannot wrap before the length compare.
  assign need = (CNT_W+2)'(a) + (CNT_W+2)'(b) + (CNT_W+2)'(1);
  assign fits = (need <= (CNT_W+2)'(TAPE_LEN));

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start && fits) state_next = S_CLEAR;
      S_CLEAR:  state_next = (cnt_a != '0) ? S_WR_A : S_SEP;
      S_WR_A:   if (cnt_a == CNT_W'(1)) state_next = S_SEP;
      S_SEP:    state_next = (cnt_b != '0) ? S_WR_B : AFTER_B;
      S_WR_B:   if (cnt_b == CNT_W'(1)) state_next = AFTER_B;
`ifdef TAPE_WRITER_REWIND_EN
      S_REWIND: if (head == HEAD_W'(2)) state_next = S_FIN;
`endif
      S_FIN:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tape  <= '0;
      head  <= HEAD_W'(1);
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && fits) begin
            cnt_a <= a;
            cnt_b <= b;
            busy  <= 1'b1;
          end else if (start) begin
            done <= 1'b1;
            err  <= 1'b1;
          end
        end
        S_CLEAR: begin
          tape <= '0;
          head <= HEAD_W'(1);
        end
        S_WR_A, S_SEP, S_WR_B: begin
          // Decoded per cell so a head past the last cell can never index out of range.
          for (int i = 1; i <= TAPE_LEN; i++)
            if (head == HEAD_W'(i)) tape[i] <= (state != S_SEP);
          head <= head + HEAD_W'(1);
          if (state == S_WR_A) cnt_a <= cnt_a - CNT_W'(1);
          if (state == S_WR_B) cnt_b <= cnt_b - CNT_W'(1);
        end
`ifdef TAPE_WRITER_REWIND_EN
        S_REWIND: head <= head - HEAD_W'(1);
`endif
        S_FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tape_writer.sv
// Self-checking bench for tape_writer: directed plan cases plus randomized operands
// checked against an arithmetic model of the expected tape, head and latency.
module tb_tape_writer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:10] tape;
  logic [3:0]  head;

  int checks = 0;
  int passes = 0;

  logic [1:10] model_tape;
  logic [3:0]  model_head;

  tape_writer dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .err(err), .tape(tape), .head(head)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:10] exp_tape(input int ta, input int tb_);
    logic [1:10] t;
    for (int i = 1; i <= 10; i++)
      t[i] = (i <= ta) || (i > ta + 1 && i <= ta + tb_ + 1);
    return t;
  endfunction

  function automatic int exp_lat(input int ta, input int tb_);
`ifdef TAPE_WRITER_REWIND_EN
    return 2 * (ta + tb_) + 4;
`else
    return ta + tb_ + 3;
`endif
  endfunction

  function automatic logic [3:0] exp_head(input int ta, input int tb_);
`ifdef TAPE_WRITER_REWIND_EN
    return 4'd1;
`else
    return 4'(ta + tb_ + 2);
`endif
  endfunction

  // Drives start now (caller picks the moment), then follows a fitting run to its done pulse.
  task automatic run_fit(input int ta, input int tb_, input string tag);
    int lat;
    bit seen;
    a = 4'(ta); b = 4'(tb_); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_accept: got %b want 1", tag, busy);
    else passes++;
    seen = 1'b0; lat = 0;
    for (int n = 1; n <= 100 && !seen; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin seen = 1'b1; lat = n; end
    end
    checks++;
    if (!seen || lat != exp_lat(ta, tb_))
      $display("FAIL %s latency: got %0d (seen=%b) want %0d", tag, lat, seen, exp_lat(ta, tb_));
    else passes++;
    checks++;
    if (tape !== exp_tape(ta, tb_)) $display("FAIL %s tape: got %b want %b", tag, tape, exp_tape(ta, tb_));
    else passes++;
    checks++;
    if (head !== exp_head(ta, tb_)) $display("FAIL %s head: got %0d want %0d", tag, head, exp_head(ta, tb_));
    else passes++;
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) $display("FAIL %s flags_at_done: got err=%b busy=%b want 0 0", tag, err, busy);
    else passes++;
    model_tape = exp_tape(ta, tb_);
    model_head = exp_head(ta, tb_);
  endtask

  // Overflowing operands: one-cycle done+err, nothing else moves.
  task automatic run_overflow(input int ta, input int tb_, input string tag);
    @(negedge clk);
    a = 4'(ta); b = 4'(tb_); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s ovf_pulse: got done=%b err=%b busy=%b want 1 1 0", tag, done, err, busy);
    else passes++;
    checks++;
    if (tape !== model_tape || head !== model_head)
      $display("FAIL %s ovf_hold: got tape=%b head=%0d want %b %0d", tag, tape, head, model_tape, model_head);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s ovf_one_cycle: got done=%b err=%b busy=%b want 0 0 0", tag, done, err, busy);
    else passes++;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (tape !== 10'b0 || head !== 4'd1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_state: got tape=%b head=%0d busy=%b done=%b err=%b want 0 1 0 0 0",
               tape, head, busy, done, err);
    else passes++;
    @(negedge clk); rst = 1'b0;
    model_tape = '0; model_head = 4'd1;
  endtask

  task automatic test_directed;
    @(negedge clk); run_fit(3, 2, "a3b2");
    checks++;
    if (tape !== 10'b1110110000) $display("FAIL a3b2_literal: got %b want 1110110000", tape);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) $display("FAIL a3b2_done_width: got %b want 0", done);
    else passes++;
    @(negedge clk); run_fit(0, 0, "a0b0");
    @(negedge clk); run_fit(4, 5, "exact_fit");
    checks++;
    if (tape !== 10'b1111011111) $display("FAIL exact_fit_literal: got %b want 1111011111", tape);
    else passes++;
    @(negedge clk); run_fit(9, 0, "a9b0");
    @(negedge clk); run_fit(0, 9, "a0b9");
  endtask

  task automatic test_overflow;
    @(negedge clk); run_fit(1, 2, "pre_ovf");
    run_overflow(5, 5, "a5b5");
    run_overflow(15, 15, "a15b15");
  endtask

  task automatic test_back_to_back;
    @(negedge clk); run_fit(3, 2, "b2b_first");
    run_fit(1, 1, "b2b_second");
  endtask

  task automatic test_busy_ignore;
    int lat;
    bit seen;
    @(negedge clk);
    a = 4'd2; b = 4'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    seen = 1'b0; lat = 0;
    for (int n = 1; n <= 100 && !seen; n++) begin
      if (n == 3) begin
        @(negedge clk); a = 4'd7; b = 4'd0; start = 1'b1;
      end
      @(posedge clk); #1; start = 1'b0;
      if (done === 1'b1) begin seen = 1'b1; lat = n; end
    end
    checks++;
    if (!seen || lat != exp_lat(2, 2)) $display("FAIL ignore_latency: got %0d want %0d", lat, exp_lat(2, 2));
    else passes++;
    checks++;
    if (tape !== 10'b1101100000) $display("FAIL ignore_tape: got %b want 1101100000", tape);
    else passes++;
    model_tape = tape === 10'b1101100000 ? 10'b1101100000 : exp_tape(2, 2);
    model_head = exp_head(2, 2);
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    a = 4'd2; b = 4'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tape !== 10'b0 || head !== 4'd1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      $display("FAIL mid_reset: got tape=%b head=%0d busy=%b done=%b err=%b want 0 1 0 0 0",
               tape, head, busy, done, err);
    else passes++;
    @(negedge clk); rst = 1'b0;
    model_tape = '0; model_head = 4'd1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL post_reset_idle: got busy=%b done=%b want 0 0", busy, done);
    else passes++;
  endtask

  task automatic test_random;
    int ta, tb_;
    for (int it = 0; it < 30; it++) begin
      ta  = $urandom_range(0, 9);
      tb_ = $urandom_range(0, 9);
      if (ta + tb_ + 1 <= 10) begin
        @(negedge clk); run_fit(ta, tb_, "random_fit");
      end else begin
        run_overflow(ta, tb_, "random_ovf");
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_overflow();
    test_back_to_back();
    test_busy_ignore();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tape_writer.md
# tape_writer

Loads an operand pair onto the 10-cell tape in the unary format the tape machine consumes: `a` ones, a single `0` separator, then `b` ones, with the rest zero-filled. It takes binary operands through a start/busy/done handshake. It writes one cell per clock while advancing a head index, mirroring the machine's one-cell-per-step head motion. It sits upstream of the tape machine, and its `tape` output drives the machine's `Dig` input.

## Interface

Parameters:
- `TAPE_LEN`, 10: number of tape cells, indexed `1..TAPE_LEN` (cell 1 is leftmost).
- `CNT_W`, 4: width of each binary operand.
- `HEAD_W`, 4: width of the head index. It must hold `TAPE_LEN+1`.

Ports:
- `clk`, input, 1: the single clock. All logic is rising-edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: request. Sampled only in IDLE.
- `a`, input, `CNT_W`: count of leading ones. Sampled with `start`.
- `b`, input, `CNT_W`: count of trailing ones. Sampled with `start`.
- `busy`, output, 1: high from the accept edge until the done edge.
- `done`, output, 1: one-cycle completion pulse.
- `err`, output, 1: one-cycle pulse, coincident with `done`, when the operands do not fit.
- `tape`, output, `[1:TAPE_LEN]`: tape contents, registered.
- `head`, output, `HEAD_W`: current head position, registered.

## Operation

States: IDLE, CLEAR, WR_A, SEP, WR_B, REWIND (only with the macro), FIN.

- **Fit check.** Compute `a+b+1` at `CNT_W+2` bits so it cannot wrap. Operands fit iff `a+b+1 <= TAPE_LEN`.
- **IDLE.**
  - `start=1` and operands fit: latch `a` and `b` into countdown registers, set `busy<=1`, go to CLEAR.
  - `start=1` and operands do not fit: set `done<=1` and `err<=1` for one cycle. `tape`, `head` and `busy` are unchanged, and the state stays IDLE.
- **CLEAR.** Set `tape<=0` and `head<=1`. Next state is WR_A if `a!=0`, else SEP.
- **WR_A.** Set `tape[head]<=1`, `head<=head+1`, decrement the count. Go to SEP after the `a`-th write.
- **SEP.** Set `tape[head]<=0`, `head<=head+1`. Next state is WR_B if `b!=0`, else FIN (or REWIND when enabled).
- **WR_B.** Same as WR_A, using `b`. After the last write go to FIN (or REWIND).
- **FIN.** Set `done<=1` and `busy<=0`, go to IDLE. `tape` holds its value until the next accepted start.
- **Boundaries:**
  - `start` while busy is ignored.
  - `a=0` and/or `b=0` are legal.
  - The exact fit `a+b+1=TAPE_LEN` leaves `head=TAPE_LEN+1` and never writes out of range.
  - `err` never coincides with `busy`.
- **Reset** at any edge, including mid-operation: state IDLE, `tape=0`, `head=1`, `busy=0`, `done=0`, `err=0`.

## Timing

- Accept edge k, fitting operands, no rewind:
  - `busy=1` from k.
  - CLEAR at k+1.
  - WR_A writes at edges k+2 through k+1+a.
  - SEP at k+2+a.
  - WR_B at k+3+a through k+2+a+b.
  - FIN at k+3+a+b, so `done=1` for exactly one cycle after that edge and `busy=0` from the same edge.
- Latency from accept to the done edge: `a+b+3` cycles.
- Overflow: `done=err=1` for the single cycle after the accept edge.
- A new `start` can be accepted on the cycle `done` is high, because the state is already IDLE.

## Configuration

- `TAPE_WRITER_REWIND_EN` defined:
  - After the last write, REWIND steps `head<=head-1` once per cycle until `head==1`, then enters FIN.
  - This adds `a+b+1` cycles, giving a total latency of `2(a+b)+4`.
  - The machine therefore starts with its head at cell 1.
- Not defined: REWIND does not exist, and `head` is left at `a+b+2` at done.

## Test plan

- Reset, then `a=3`, `b=2`, `start` at edge k -> `tape=1110110000`, `done` pulse after edge k+8, `head=7`, `err=0`.
- `a=0`, `b=0` -> `tape=0000000000` (CLEAR then SEP only), `done` after edge k+3.
- `a=4`, `b=5` (exact fit) -> `tape=1111011111`, `head=11`, no `err`.
- `a=5`, `b=5` -> `done=err=1` for one cycle after edge k, `busy` stays 0, prior `tape` unchanged.
- `start` with `a=7` pulsed during an `a=2`, `b=2` run; then `rst` asserted at k+3 on a second run -> first run yields `1101100000`; after reset `tape=0`, `head=1`, all flags 0.
- With `TAPE_WRITER_REWIND_EN`, `a=3`, `b=2` -> same tape, `head=1` at done, `done` after edge k+14.
